// File: rtl/and_gate_event_counter.sv
// and_gate_event_counter
//   Samples gate inputs A and B, synchronizes them, debounces their AND and
//   counts qualified rising events of the debounced level.
//
// Ports:
//   clk      tile clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable; low discards rising events (sync/debounce keep running)
//   ui_in    [0] input A, [1] input B, [2] clear, [7:3] unused
//   uo_out   event count
//   uio_in   unused
//   uio_out  [0] debounced AND level, [1] sticky overflow, [7:2] zero
//   uio_oe   constant 8'h03
module and_gate_event_counter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // A single debounce cycle still needs a 1-bit counter to stay well-formed.
  localparam int DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0]      DCNT_MAX  = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q, sync_c_q;
  logic                   db_q, db_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic s_s;
  logic clr_s;
  logic rise_s;
  logic unused_s;

  assign s_s   = sync_a_q[SYNC_STAGES-1] & sync_b_q[SYNC_STAGES-1];
  assign clr_s = sync_c_q[SYNC_STAGES-1];

  // db is about to go 0->1 on this edge.
  assign rise_s = s_s & ~db_q & (dcnt_q == DCNT_MAX);

  // Input synchronizer chains for A, B and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      sync_c_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], ui_in[0]};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], ui_in[1]};
      sync_c_q <= {sync_c_q[SYNC_STAGES-2:0], ui_in[2]};
    end
  end

  // Debounce next state: a changed level is accepted only after it persists.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    if (s_s == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      db_d   = s_s;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  // Counter next state: clear wins over a simultaneous qualified rise.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_s) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rise_s && ena) begin
      count_d = count_q + COUNT_WIDTH'(1);
      if (count_q == COUNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // Debounce and counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q    <= 1'b0;
      dcnt_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uo_out  = count_q;
  assign uio_out = {6'b00_0000, ovf_q, db_q};
  assign uio_oe  = 8'h03;

  // Inputs with no function in this tile.
  assign unused_s = &{1'b0, ui_in[7:3], uio_in};

endmodule
